// File: rtl/popcnt_arb.sv
// popcnt_arb: round-robin arbiter sharing one popcount core among NREQ requesters.
// Latency: accept -> issue next cycle -> response one cycle after core_val_i (4-cycle minimum accept spacing).
// Backpressure: one transaction in flight, req_rdy_o held 0 outside IDLE; POPCNT_ARB_TIMEOUT_EN adds a WAIT watchdog.
module popcnt_arb #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NREQ-1:0]            req_val_i,
  input  logic [NREQ*WIDTH-1:0]      req_data_i,
  output logic [NREQ-1:0]            req_rdy_o,
  output logic                       core_val_o,
  output logic [WIDTH-1:0]           core_data_o,
  input  logic                       core_val_i,
  input  logic [$clog2(WIDTH)+1:0]   core_data_i,
  output logic [NREQ-1:0]            resp_val_o,
  output logic [$clog2(WIDTH)+1:0]   resp_data_o,
  output logic                       resp_err_o
);

  localparam int GW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   grant_idx;
  logic            grant_any;
  int              pos;

`ifdef POPCNT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]   wd_cnt;
  logic            err_q;
  assign resp_err_o = err_q;
`else
  assign resp_err_o = 1'b0;
`endif

  // Round-robin pick: scan offsets from the far end so the nearest requester after last_grant wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = last_grant;
    pos       = 0;
    for (int off = NREQ; off >= 1; off--) begin
      pos = (int'(last_grant) + off) % NREQ;
      if (req_val_i[pos[GW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = GW'(pos);
      end
    end
  end

  // Accept strobe is combinational so the requester sees it in the same IDLE cycle.
  always_comb begin
    req_rdy_o = '0;
    if (state == IDLE && grant_any) begin
      req_rdy_o[grant_idx] = 1'b1;
    end
  end

  // Transaction FSM with registered core/response outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      last_grant  <= GW'(NREQ - 1);
      core_val_o  <= 1'b0;
      core_data_o <= '0;
      resp_val_o  <= '0;
      resp_data_o <= '0;
`ifdef POPCNT_ARB_TIMEOUT_EN
      wd_cnt      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            core_data_o <= req_data_i[int'(grant_idx)*WIDTH +: WIDTH];
            last_grant  <= grant_idx;
            core_val_o  <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          core_val_o <= 1'b0;
          state      <= WAIT;
`ifdef POPCNT_ARB_TIMEOUT_EN
          wd_cnt     <= '0;
`endif
        end
        WAIT: begin
          // A core answer arriving on the final watchdog cycle still wins.
          if (core_val_i) begin
            resp_data_o <= core_data_i;
            resp_val_o  <= ONE << last_grant;
            state       <= RESP;
`ifdef POPCNT_ARB_TIMEOUT_EN
            err_q       <= 1'b0;
          end else if (wd_cnt == TW'(TIMEOUT - 1)) begin
            resp_data_o <= '0;
            err_q       <= 1'b1;
            resp_val_o  <= ONE << last_grant;
            state       <= RESP;
          end else begin
            wd_cnt      <= wd_cnt + TW'(1);
`endif
          end
        end
        RESP: begin
          resp_val_o <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_popcnt_arb.sv
// Bench for popcnt_arb: table of directed transactions, reset/timeout sequences,
// then randomized traffic against a queue-based round-robin reference.
// The bench plays the popcount core itself.
module tb_popcnt_arb;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int T  = 64;
  localparam int CW = $clog2(W) + 2;
  localparam logic [N*W-1:0] D = {32'h0000_000F, 32'h0000_0007, 32'h0000_0003, 32'h0000_0001};

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic [N-1:0]    req_val_i = '0;
  logic [N*W-1:0]  req_data_i = '0;
  logic [N-1:0]    req_rdy_o;
  logic            core_val_o;
  logic [W-1:0]    core_data_o;
  logic            core_val_i = 1'b0;
  logic [CW-1:0]   core_data_i = '0;
  logic [N-1:0]    resp_val_o;
  logic [CW-1:0]   resp_data_o;
  logic            resp_err_o;

  int total = 0;
  int bad   = 0;
  int model_last;

  always #5 clk = ~clk;

  popcnt_arb #(.WIDTH(W), .NREQ(N), .TIMEOUT(T)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_val_i(req_val_i), .req_data_i(req_data_i), .req_rdy_o(req_rdy_o),
    .core_val_o(core_val_o), .core_data_o(core_data_o),
    .core_val_i(core_val_i), .core_data_i(core_data_i),
    .resp_val_o(resp_val_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o)
  );

  typedef struct {
    logic         rst;
    logic [N-1:0] rv;
    logic [N*W-1:0] dat;
    int           lat;
    int           g;
    int           cnt;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference arbiter: list requesters in rotation order after the last winner, take the first asking.
  function automatic int rr_pick(input logic [N-1:0] rv, input int last);
    int order[$];
    int pick;
    pick = -1;
    for (int n = 1; n <= N; n++) order.push_back((last + n) % N);
    foreach (order[j]) if (pick < 0 && rv[order[j]]) pick = order[j];
    return pick;
  endfunction

  // Called just after a negedge with the DUT in IDLE; returns just after a negedge back in IDLE.
  task automatic do_reset(input string nm);
    rst_i = 1'b1;
    req_val_i = '0;
    core_val_i = 1'b0;
    #1;
    chk({nm, ".rdy"}, req_rdy_o, 0);
    chk({nm, ".core_val"}, core_val_o, 0);
    chk({nm, ".core_data"}, core_data_o, 0);
    chk({nm, ".resp_val"}, resp_val_o, 0);
    chk({nm, ".resp_data"}, resp_data_o, 0);
    chk({nm, ".resp_err"}, resp_err_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic run_txn(input logic [N-1:0] rv, input logic [N*W-1:0] dat, input int lat,
                         input int g, input int cnt, input bit scram, input string nm);
    logic [W-1:0] w;
    w = dat[g*W +: W];
    req_val_i = rv;
    req_data_i = dat;
    #1;
    chk({nm, ".rdy"}, req_rdy_o, 64'd1 << g);
    @(negedge clk);
    if (scram) begin
      req_val_i = N'($urandom);
      req_data_i = {$urandom, $urandom, $urandom, $urandom};
      core_val_i = 1'b1;
      core_data_i = CW'($urandom);
    end
    #1;
    chk({nm, ".issue_val"}, core_val_o, 1);
    chk({nm, ".issue_data"}, core_data_o, w);
    chk({nm, ".issue_rdy"}, req_rdy_o, 0);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (scram) begin
        req_val_i = N'($urandom);
        req_data_i = {$urandom, $urandom, $urandom, $urandom};
      end
      core_val_i = (i == lat);
      core_data_i = (i == lat) ? CW'(cnt) : CW'($urandom);
      #1;
      chk({nm, ".wait_core_val"}, core_val_o, 0);
      chk({nm, ".wait_resp_val"}, resp_val_o, 0);
      chk({nm, ".wait_rdy"}, req_rdy_o, 0);
    end
    @(negedge clk);
    core_val_i = scram;
    core_data_i = scram ? CW'($urandom) : '0;
    #1;
    chk({nm, ".resp_val"}, resp_val_o, 64'd1 << g);
    chk({nm, ".resp_data"}, resp_data_o, cnt);
    chk({nm, ".resp_err"}, resp_err_o, 0);
    chk({nm, ".resp_rdy"}, req_rdy_o, 0);
    @(negedge clk);
    core_val_i = 1'b0;
    #1;
    chk({nm, ".idle_resp_val"}, resp_val_o, 0);
    chk({nm, ".idle_hold"}, resp_data_o, cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench did not complete");
  end

  initial begin
    logic [N-1:0]   rv;
    logic [N*W-1:0] dat;
    int             g;
    int             lat;
    int             waited;
    int             seen;

    vecs[0]  = '{1'b1, 4'b0100, {32'h0, 32'h0000_00FF, 32'h0, 32'h0}, 1, 2, 8};
    vecs[1]  = '{1'b1, 4'b1111, D, 1, 0, 1};
    vecs[2]  = '{1'b0, 4'b1111, D, 1, 1, 2};
    vecs[3]  = '{1'b0, 4'b1111, D, 2, 2, 3};
    vecs[4]  = '{1'b0, 4'b1111, D, 1, 3, 4};
    vecs[5]  = '{1'b0, 4'b1111, D, 1, 0, 1};
    vecs[6]  = '{1'b0, 4'b1010, D, 1, 1, 2};
    vecs[7]  = '{1'b0, 4'b1010, D, 3, 3, 4};
    vecs[8]  = '{1'b0, 4'b1010, D, 1, 1, 2};
    vecs[9]  = '{1'b0, 4'b0001, {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF}, 1, 0, 32};
    vecs[10] = '{1'b0, 4'b0010, {32'h0, 32'h0, 32'h0, 32'h0}, 2, 1, 0};

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].rst) do_reset($sformatf("rst%0d", i));
      run_txn(vecs[i].rv, vecs[i].dat, vecs[i].lat, vecs[i].g, vecs[i].cnt, 1'b0,
              $sformatf("vec%0d", i));
    end

    // Reset while waiting on the core: no response, late core answer ignored, requester 0 wins next.
    req_val_i = 4'b0100;
    req_data_i = D;
    #1;
    chk("abort.rdy", req_rdy_o, 4'b0100);
    @(negedge clk);
    req_val_i = '0;
    #1;
    chk("abort.issue", core_val_o, 1);
    @(negedge clk);
    do_reset("abort.rst");
    @(negedge clk);
    core_val_i = 1'b1;
    core_data_i = CW'(5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      core_val_i = 1'b0;
      #1;
      chk($sformatf("abort.no_resp%0d", i), resp_val_o, 0);
      chk($sformatf("abort.no_issue%0d", i), core_val_o, 0);
    end
    chk("abort.data_clear", resp_data_o, 0);
    run_txn(4'b1111, D, 1, 0, 1, 1'b0, "post_rst");

    // Randomized traffic with in-flight disturbances.
    do_reset("rnd.rst");
    model_last = N - 1;
    for (int i = 0; i < 40; i++) begin
      rv  = N'($urandom_range(1, 15));
      dat = {$urandom, $urandom, $urandom, $urandom};
      lat = $urandom_range(1, 4);
      g   = rr_pick(rv, model_last);
      run_txn(rv, dat, lat, g, $countones(dat[g*W +: W]), 1'b1, $sformatf("rnd%0d", i));
      model_last = g;
    end

    // Silent core.
    req_val_i = 4'b0010;
    req_data_i = {32'h0, 32'h0, 32'h0000_00FF, 32'h0};
    #1;
    chk("silent.rdy", req_rdy_o, 4'b0010);
    @(negedge clk);
    req_val_i = '0;
    #1;
    chk("silent.issue", core_val_o, 1);
`ifdef POPCNT_ARB_TIMEOUT_EN
    waited = 0;
    do begin
      @(negedge clk);
      #1;
      waited++;
    end while (resp_val_o == '0 && waited < 200);
    chk("to.cycles", waited, T + 1);
    chk("to.resp_val", resp_val_o, 4'b0010);
    chk("to.err", resp_err_o, 1);
    chk("to.data", resp_data_o, 0);
    @(negedge clk);
    #1;
    chk("to.idle", resp_val_o, 0);
    chk("to.err_hold", resp_err_o, 1);
    run_txn(4'b0001, D, 1, 0, 1, 1'b0, "after_to");
`else
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      #1;
      if (resp_val_o != '0) seen++;
    end
    chk("no_to.resp", seen, 0);
    chk("no_to.err", resp_err_o, 0);
    core_val_i = 1'b1;
    core_data_i = CW'(8);
    @(negedge clk);
    core_val_i = 1'b0;
    #1;
    chk("no_to.resp_val", resp_val_o, 4'b0010);
    chk("no_to.data", resp_data_o, 8);
    chk("no_to.err_late", resp_err_o, 0);
    @(negedge clk);
    #1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
